sma_sample_feeder: RTL and testbench
====================================

# sma_sample_feeder

Paced sample source that drives the valid-only input stream of the moving-average filter. Upstream logic pushes samples through a valid/ready handshake into a small FIFO. The feeder primes the FIFO to a fill threshold, then emits one sample on `out_data`/`out_data_valid` every `rate_div+1` cycles, giving the filter a steady, gap-controlled cadence. Underruns are flagged and counted.

## Interface
- `DATA_WIDTH`, 16, sample width; matches the filter's input width.
- `FIFO_DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `PRIME_LEVEL`, 4, fill level required before emission starts or resumes; 1 ≤ `PRIME_LEVEL` ≤ `FIFO_DEPTH`.
- `RATE_WIDTH`, 8, width of `rate_div`.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = run the pacing FSM; 0 = stop emitting.
- `rate_div`  in  `RATE_WIDTH`  emission period minus one, in cycles.
- `s_data`  in  `DATA_WIDTH`  upstream sample.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  FIFO can accept a sample.
- `out_data`  out  `DATA_WIDTH`  paced sample to the filter; registered.
- `out_data_valid`  out  1  one-cycle strobe per emitted sample; registered.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy; registered.
- `underrun`  out  1  one-cycle pulse when a pacing tick finds the FIFO empty.
- `underrun_count`  out  16  number of underruns; saturating.

## Operation
- FIFO
  - Push occurs when `s_valid & s_ready`.
  - `s_ready = (fifo_level != FIFO_DEPTH)`, driven combinationally from the level register. There is no full-bypass.
  - Pop occurs only on a RUN-state tick when `fifo_level != 0`. There is no empty-bypass: a push in the same cycle cannot satisfy that tick.
  - Push and pop in the same cycle leave the level unchanged. Read and write pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: the pace counter is held at 0 and nothing is emitted. The FIFO still accepts pushes. If `enable` = 1, the next state is PRIME.
  - PRIME: if `enable` = 0, go to IDLE. Else if `fifo_level >= PRIME_LEVEL`, go to RUN with the pace counter loaded to 0.
  - RUN: if `enable` = 0, go to IDLE; no tick is processed that cycle and the FIFO contents are retained.
    - A tick occurs when the pace counter is 0.
    - On a tick with the FIFO non-empty: pop, register the head into `out_data`, set `out_data_valid` = 1 for the next cycle, and reload the pace counter with the current `rate_div`.
    - On a tick with the FIFO empty: pulse `underrun`, increment `underrun_count` (saturating at 16'hFFFF), and go to PRIME.
    - When the pace counter is not 0, it decrements.
- `rate_div` is sampled only at reload, so a change takes effect from the next period. `rate_div` = 0 emits every cycle.
- `out_data` holds its last value when `out_data_valid` = 0.
- `underrun_count` is cleared only by reset.

## Timing
- Reset values:
  - state = IDLE, pace counter = 0, pointers = 0.
  - `fifo_level` = 0, so `s_ready` = 1.
  - `out_data` = 0, `out_data_valid` = 0, `underrun` = 0, `underrun_count` = 0.
  - FIFO contents need no reset.
- A push at edge k makes the new `fifo_level` visible in cycle k+1.
- First emission: with `fifo_level` ≥ `PRIME_LEVEL` visible in PRIME cycle t, state = RUN in t+1, the pop happens in t+1, and `out_data_valid` = 1 in t+2.
- Steady state in RUN with no underrun: strobes are exactly `rate_div+1` cycles apart.
- Underrun: `underrun` is high the cycle after the empty tick, in the same cycle the state shows PRIME. Re-prime then follows the first-emission timing.
- `enable` falling in cycle t suppresses any tick in t. No `out_data_valid` appears in t+1 or later until re-primed.
- Asynchronous reset mid-operation forces all reset values immediately; buffered samples are discarded.

## Test plan
- **Reset and idle:** release reset with `enable` = 0 and push 8 samples 1..8. Required: `s_ready` = 0 after the 8th push, `fifo_level` = 8, no `out_data_valid`; a 9th `s_valid` is not accepted.
- **Prime and cadence:** `PRIME_LEVEL` = 4, `rate_div` = 3. Push 0x0010..0x0013, then set `enable` = 1. Required: the first strobe carries 0x0010; the following strobes carry 0x0011, 0x0012, 0x0013, each 4 cycles after the previous one; then `underrun` = 1 once, `underrun_count` = 1, and state returns to PRIME.
- **Full rate with concurrent traffic:** `rate_div` = 0 with a continuous push stream 0..99 after priming. Required: `out_data_valid` is high every cycle, the output sequence is 0..99 in order, and `fifo_level` stays constant at 4 during concurrent push/pop.
- **Rate change mid-period:** while running with `rate_div` = 5, change it to 1 two cycles after a strobe. Required: the next gap is still 6 cycles and subsequent gaps are 2 cycles.
- **Enable drop and resume:** deassert `enable` with 3 samples buffered. Required: no strobes, `fifo_level` stays 3, and after re-enable emission restarts only once `fifo_level` ≥ 4, in original order.
- **Reset and saturation:** assert `rstn` low mid-RUN with 5 samples buffered. Required: all outputs at reset values immediately and no stale sample after release. Separately, force 65537 underruns; required: `underrun_count` = 16'hFFFF.

Source files
------------

// File: rtl/sma_sample_feeder.sv
// sma_sample_feeder
// Paced sample source for the moving-average filter. Upstream samples enter a
// small FIFO through a valid/ready handshake; once the FIFO reaches the prime
// level the pacing FSM pops one sample every rate_div+1 cycles and presents it
// as a registered one-cycle strobe. Empty ticks are flagged and counted.
module sma_sample_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4,
  parameter int RATE_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic [RATE_WIDTH-1:0]         rate_div,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  // Storage: no reset needed, validity is tracked by the level/pointers.
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q,  level_d;
  state_e                state_q,  state_d;
  logic [RATE_WIDTH-1:0] pace_q,   pace_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_vld_q,  out_vld_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           ucnt_q,     ucnt_d;

  logic push;
  logic pop;

  // Ready comes straight from the level register; a full FIFO never bypasses.
  assign s_ready = (level_q != FULL_LVL);
  assign push    = s_valid & s_ready;

  // Pacing FSM: decides ticks, pops, strobes and underrun bookkeeping.
  always_comb begin
    state_d    = state_q;
    pace_d     = pace_q;
    out_data_d = out_data_q;
    out_vld_d  = 1'b0;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        pace_d = '0;
        if (enable) state_d = S_PRIME;
      end
      S_PRIME: begin
        if (!enable) begin
          state_d = S_IDLE;
          pace_d  = '0;
        end else if (level_q >= PRIME_LVL) begin
          state_d = S_RUN;
          pace_d  = '0;
        end
      end
      S_RUN: begin
        if (!enable) begin
          // Dropping enable cancels this cycle's tick; FIFO keeps its samples.
          state_d = S_IDLE;
          pace_d  = '0;
        end else if (pace_q == '0) begin
          if (level_q != '0) begin
            pop        = 1'b1;
            out_data_d = mem_q[rd_ptr_q];
            out_vld_d  = 1'b1;
            // rate_div is only looked at here, so changes apply next period.
            pace_d     = rate_div;
          end else begin
            underrun_d = 1'b1;
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
            state_d    = S_PRIME;
          end
        end else begin
          pace_d = pace_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pace_d  = '0;
      end
    endcase
  end

  // FIFO pointer and occupancy update; simultaneous push/pop keeps the level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Sample storage write port.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      pace_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pace_q     <= pace_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_data_valid = out_vld_q;
  assign fifo_level     = level_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_sma_sample_feeder.sv
// Scoreboard bench for sma_sample_feeder: stimulus pushes the expected sample
// order into a queue, a negedge monitor pops and compares on every strobe and
// logs strobe/underrun cycles for cadence checks.
module tb_sma_sample_feeder;
  localparam int DW = 16, DEPTH = 8, PL = 4, RW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic [RW-1:0] rate_div = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] out_data;
  logic          out_data_valid;
  logic [3:0]    fifo_level;
  logic          underrun;
  logic [15:0]   underrun_count;

  sma_sample_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PL), .RATE_WIDTH(RW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .rate_div(rate_div),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .out_data(out_data), .out_data_valid(out_data_valid),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] exp_q[$];
  int strobe_cyc[$];
  int n_strobe = 0, n_under = 0, under_cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every strobe against the scoreboard head.
  always @(negedge clk) begin
    if (rstn) begin
      if (out_data_valid) begin
        n_strobe++;
        strobe_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_strobe: got data %0h, expected no strobe (cycle %0d)", out_data, cyc);
        end else begin
          chk("strobe_data", out_data, exp_q.pop_front());
        end
      end
      if (underrun) begin
        n_under++;
        under_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic push(input logic [DW-1:0] d);
    chk("push_ready", s_ready, 1);
    s_valid = 1'b1; s_data = d;
    exp_q.push_back(d);
    step(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int k = 0;
    while (n_strobe < target && k < budget) begin step(1); k++; end
    chk("strobe_timeout", n_strobe, target);
  endtask

  task automatic wait_under(input int target, input int budget);
    int k = 0;
    while (n_under < target && k < budget) begin step(1); k++; end
    chk("underrun_timeout", n_under, target);
  endtask

  task automatic check_gaps(input int base, input int cnt, input int gap, input string nm);
    for (int i = 0; i < cnt; i++)
      chk(nm, strobe_cyc[base+i+1] - strobe_cyc[base+i], gap);
  endtask

  task automatic do_reset();
    enable = 1'b0; s_valid = 1'b0;
    rstn = 1'b0;
    step(2);
    exp_q.delete();
    rstn = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n0, u0, t0, k;

    // Reset values and idle filling.
    step(2);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_data_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ucount", underrun_count, 0);
    rstn = 1'b1;
    step(1);
    for (int i = 1; i <= 8; i++) push(16'(i));
    chk("full_s_ready", s_ready, 0);
    chk("full_level", fifo_level, 8);
    s_valid = 1'b1; s_data = 16'd9;
    step(2);
    s_valid = 1'b0;
    chk("ninth_rejected_level", fifo_level, 8);
    chk("idle_no_strobe", n_strobe, 0);
    do_reset();

    // Prime and cadence, underrun, then re-prime without toggling enable.
    rate_div = 8'd3;
    for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i));
    base = strobe_cyc.size(); n0 = n_strobe; u0 = n_under;
    t0 = cyc;
    enable = 1'b1;
    wait_strobes(n0 + 4, 60);
    wait_under(u0 + 1, 30);
    chk("first_emit_latency", strobe_cyc[base] - t0, 3);
    check_gaps(base, 3, 4, "cadence_gap");
    chk("underrun_delay", under_cyc - strobe_cyc[base+3], 4);
    chk("ucount_one", underrun_count, 1);
    step(5);
    chk("single_underrun", n_under - u0, 1);
    base = strobe_cyc.size(); n0 = n_strobe;
    for (int i = 0; i < 4; i++) push(16'h0020 + 16'(i));
    t0 = cyc;
    wait_strobes(n0 + 4, 60);
    chk("reprime_latency", strobe_cyc[base] - t0, 2);
    do_reset();

    // Full rate with concurrent push/pop.
    rate_div = 8'd0;
    enable = 1'b1;
    step(2);
    base = strobe_cyc.size(); n0 = n_strobe;
    for (int i = 0; i < 4; i++) push(16'(i));
    step(1);
    for (int i = 4; i < 100; i++) begin
      push(16'(i));
      chk("level_const", fifo_level, 4);
    end
    wait_strobes(n0 + 100, 50);
    check_gaps(base, 99, 1, "fullrate_gap");
    chk("fullrate_drained", exp_q.size(), 0);
    do_reset();

    // Rate change two cycles after a strobe.
    rate_div = 8'd5;
    for (int i = 0; i < 8; i++) push(16'h0040 + 16'(i));
    enable = 1'b1;
    k = 0;
    while (!out_data_valid && k < 50) begin step(1); k++; end
    chk("ratechg_first_strobe", out_data_valid, 1);
    base = strobe_cyc.size() - 1; n0 = n_strobe - 1;
    step(2);
    rate_div = 8'd1;
    wait_strobes(n0 + 8, 80);
    chk("ratechg_old_gap", strobe_cyc[base+1] - strobe_cyc[base], 6);
    check_gaps(base + 1, 6, 2, "ratechg_new_gap");
    do_reset();

    // Enable drop with 3 buffered, resume only after re-prime.
    rate_div = 8'd3;
    for (int i = 0; i < 5; i++) push(16'h0050 + 16'(i));
    n0 = n_strobe;
    enable = 1'b1;
    wait_strobes(n0 + 2, 40);
    enable = 1'b0;
    chk("drop_level", fifo_level, 3);
    step(10);
    chk("drop_level_hold", fifo_level, 3);
    chk("drop_no_strobe", n_strobe - n0, 2);
    enable = 1'b1;
    step(10);
    chk("resume_wait_prime", n_strobe - n0, 2);
    chk("resume_level", fifo_level, 3);
    push(16'h0055);
    wait_strobes(n0 + 6, 60);
    chk("resume_drained", exp_q.size(), 0);
    do_reset();

    // Asynchronous reset mid-RUN with 5 buffered.
    rate_div = 8'd3;
    for (int i = 0; i < 8; i++) push(16'h0060 + 16'(i));
    n0 = n_strobe;
    enable = 1'b1;
    wait_strobes(n0 + 3, 40);
    chk("prereset_level", fifo_level, 5);
    #2 rstn = 1'b0;
    #1;
    chk("arst_level", fifo_level, 0);
    chk("arst_s_ready", s_ready, 1);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_valid", out_data_valid, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_ucount", underrun_count, 0);
    exp_q.delete();
    step(2);
    rstn = 1'b1;
    n0 = n_strobe;
    step(20);
    chk("no_stale_strobe", n_strobe - n0, 0);
    chk("no_stale_level", fifo_level, 0);
    chk("no_stale_data", out_data, 0);

    // Saturation: preload the counter near full scale, then cause underruns.
    rate_div = 8'd0;
    force dut.ucnt_q = 16'hFFFD;
    #1;
    release dut.ucnt_q;
    step(1);
    chk("sat_preload", underrun_count, 16'hFFFD);
    for (int r = 0; r < 3; r++) begin
      u0 = n_under;
      for (int i = 0; i < 4; i++) push(16'h0070 + 16'(4*r + i));
      wait_under(u0 + 1, 40);
      chk("sat_count", underrun_count, (r == 0) ? 16'hFFFE : 16'hFFFF);
    end
    chk("sat_drained", exp_q.size(), 0);
    enable = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
